// File: rtl/file_op_sequencer_pkg.sv
// file_op_sequencer_pkg: opcodes, encodings, STATUS bit indices and decode helpers.
// SEQ_BITOPS_EN enables decoding of BCF/BSF/BTFSC/BTFSS; otherwise they decode as illegal.
package file_op_sequencer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE_F, S_WRITE_S} state_e;

    typedef enum logic [2:0] {WC_NONE = 3'b000, WC_STATUS = 3'b001, WC_FILE = 3'b010} wcmd_e;

    localparam int ST_Z  = 2;
    localparam int ST_DC = 1;
    localparam int ST_C  = 0;

    localparam logic [2:0] FLAG_Z   = 3'b100;
    localparam logic [2:0] FLAG_ALL = 3'b111;
    localparam logic [2:0] FLAG_C   = 3'b001;

    typedef enum logic [4:0] {
        OP_NOP, OP_MOVWF, OP_CLRW, OP_CLRF, OP_SUBWF, OP_DECF, OP_IORWF, OP_ANDWF,
        OP_XORWF, OP_ADDWF, OP_MOVF, OP_COMF, OP_INCF, OP_DECFSZ, OP_RRF, OP_RLF,
        OP_SWAPF, OP_INCFSZ, OP_BCF, OP_BSF, OP_BTFSC, OP_BTFSS, OP_ILLEGAL
    } op_e;

    function automatic op_e decode(input logic [11:0] i);
        op_e o;
        casez (i)
            12'b0000_0000_0000: o = OP_NOP;
            12'b0000_001?_????: o = OP_MOVWF;
            12'b0000_010?_????: o = OP_CLRW;
            12'b0000_011?_????: o = OP_CLRF;
            12'b0000_10??_????: o = OP_SUBWF;
            12'b0000_11??_????: o = OP_DECF;
            12'b0001_00??_????: o = OP_IORWF;
            12'b0001_01??_????: o = OP_ANDWF;
            12'b0001_10??_????: o = OP_XORWF;
            12'b0001_11??_????: o = OP_ADDWF;
            12'b0010_00??_????: o = OP_MOVF;
            12'b0010_01??_????: o = OP_COMF;
            12'b0010_10??_????: o = OP_INCF;
            12'b0010_11??_????: o = OP_DECFSZ;
            12'b0011_00??_????: o = OP_RRF;
            12'b0011_01??_????: o = OP_RLF;
            12'b0011_10??_????: o = OP_SWAPF;
            12'b0011_11??_????: o = OP_INCFSZ;
`ifdef SEQ_BITOPS_EN
            12'b0100_????_????: o = OP_BCF;
            12'b0101_????_????: o = OP_BSF;
            12'b0110_????_????: o = OP_BTFSC;
            12'b0111_????_????: o = OP_BTFSS;
`endif
            default:            o = OP_ILLEGAL;
        endcase
        return o;
    endfunction

    function automatic logic byte_op(input op_e op);
        return op inside {OP_SUBWF, OP_DECF, OP_IORWF, OP_ANDWF, OP_XORWF, OP_ADDWF, OP_MOVF,
                          OP_COMF, OP_INCF, OP_DECFSZ, OP_RRF, OP_RLF, OP_SWAPF, OP_INCFSZ};
    endfunction

    function automatic logic dest_f(input op_e op, input logic d);
        return (op inside {OP_MOVWF, OP_CLRF, OP_BCF, OP_BSF}) || (d && byte_op(op));
    endfunction

    function automatic logic dest_w(input op_e op, input logic d);
        return (op == OP_CLRW) || (!d && byte_op(op));
    endfunction

    // Mask bit positions line up with the STATUS bits they replace.
    function automatic logic [2:0] flag_mask(input op_e op);
        return (op inside {OP_ADDWF, OP_SUBWF}) ? FLAG_ALL :
               (op inside {OP_ANDWF, OP_IORWF, OP_XORWF, OP_COMF, OP_DECF, OP_INCF,
                           OP_MOVF, OP_CLRF, OP_CLRW}) ? FLAG_Z :
               (op inside {OP_RLF, OP_RRF}) ? FLAG_C : 3'b000;
    endfunction

endpackage

// File: rtl/file_op_sequencer_if.sv
// file_op_sequencer_if: instruction handshake and register-file/STATUS bus of the sequencer.
interface file_op_sequencer_if;
    logic        instValid;
    logic [11:0] instIn;
    logic        instReady;
    logic [7:0]  regfileIn;
    logic [7:0]  statusIn;
    logic [2:0]  writeCommand;
    logic [4:0]  fileAddr;
    logic [7:0]  writeDataOut;
    logic [7:0]  statusOut;
    logic [7:0]  wOut;
    logic        done;
    logic        skipOut;
    logic        illegalOut;

    modport master (
        output instValid, instIn, regfileIn, statusIn,
        input  instReady, writeCommand, fileAddr, writeDataOut, statusOut, wOut, done, skipOut, illegalOut
    );

    modport slave (
        input  instValid, instIn, regfileIn, statusIn,
        output instReady, writeCommand, fileAddr, writeDataOut, statusOut, wOut, done, skipOut, illegalOut
    );
endinterface

// File: rtl/file_op_sequencer_alu.sv
// file_alu: combinational datapath for PIC16C5x byte/bit-oriented file operations.
module file_alu
    import file_op_sequencer_pkg::*;
(
    input  op_e        op,
    input  logic [7:0] f_in,
    input  logic [7:0] w_in,
    input  logic       c_in,
    input  logic [2:0] b,
    output logic [7:0] result,
    output logic       z,
    output logic       dc,
    output logic       c
);
    logic [8:0] add, sub;
    logic [4:0] add_lo, sub_lo;
    logic [7:0] bit_m;

    // Subtraction is f + ~W + 1 so carry-out reads as "no borrow".
    assign add    = {1'b0, f_in} + {1'b0, w_in};
    assign sub    = {1'b0, f_in} + {1'b0, ~w_in} + 9'd1;
    assign add_lo = {1'b0, f_in[3:0]} + {1'b0, w_in[3:0]};
    assign sub_lo = {1'b0, f_in[3:0]} + {1'b0, ~w_in[3:0]} + 5'd1;
    assign bit_m  = 8'd1 << b;
    assign z      = result == 8'h00;

    always_comb begin
        result = f_in;
        c      = c_in;
        dc     = 1'b0;
        case (op)
            OP_ADDWF:            begin result = add[7:0]; c = add[8]; dc = add_lo[4]; end
            OP_SUBWF:            begin result = sub[7:0]; c = sub[8]; dc = sub_lo[4]; end
            OP_ANDWF:            result = f_in & w_in;
            OP_IORWF:            result = f_in | w_in;
            OP_XORWF:            result = f_in ^ w_in;
            OP_COMF:             result = ~f_in;
            OP_DECF, OP_DECFSZ:  result = f_in - 8'd1;
            OP_INCF, OP_INCFSZ:  result = f_in + 8'd1;
            OP_CLRF, OP_CLRW:    result = 8'h00;
            OP_MOVWF:            result = w_in;
            OP_RRF:              begin result = {c_in, f_in[7:1]}; c = f_in[0]; end
            OP_RLF:              begin result = {f_in[6:0], c_in}; c = f_in[7]; end
            OP_SWAPF:            result = {f_in[3:0], f_in[7:4]};
            OP_BCF:              result = f_in & ~bit_m;
            OP_BSF:              result = f_in | bit_m;
            default:             result = f_in;
        endcase
    end
endmodule

// File: rtl/file_op_sequencer.sv
// file_op_sequencer: IDLE->READ->WRITE_F[->WRITE_S] sequencer for PIC16C5x file instructions.
// Bit ops (BCF/BSF/BTFSC/BTFSS) execute only when SEQ_BITOPS_EN is defined.
module file_op_sequencer
    import file_op_sequencer_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    file_op_sequencer_if.slave   bus
);
    state_e      state_q, state_d;
    logic [11:0] inst_q, inst_d;
    logic [7:0]  result_q, result_d;
    logic [7:0]  w_q, w_d;
    logic [2:0]  flags_q, flags_d;
    logic        skip_q, skip_d;

    op_e        op;
    logic [2:0] mask;
    logic       wr_f, wr_w, bit_val, done;
    logic [7:0] alu_res;
    logic       alu_z, alu_dc, alu_c;

    assign op      = decode(inst_q);
    assign mask    = flag_mask(op);
    assign wr_f    = dest_f(op, inst_q[5]);
    assign wr_w    = dest_w(op, inst_q[5]);
    assign bit_val = bus.regfileIn[inst_q[7:5]];

    file_alu u_alu (
        .op     (op),
        .f_in   (bus.regfileIn),
        .w_in   (w_q),
        .c_in   (bus.statusIn[ST_C]),
        .b      (inst_q[7:5]),
        .result (alu_res),
        .z      (alu_z),
        .dc     (alu_dc),
        .c      (alu_c)
    );

    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        result_d = result_q;
        flags_d  = flags_q;
        skip_d   = skip_q;
        w_d      = w_q;
        case (state_q)
            S_IDLE: if (bus.instValid) begin
                state_d = S_READ;
                inst_d  = bus.instIn;
            end
            S_READ: begin
                state_d  = S_WRITE_F;
                result_d = alu_res;
                flags_d  = {alu_z, alu_dc, alu_c};
                skip_d   = (op inside {OP_DECFSZ, OP_INCFSZ}) ? alu_z :
                           (op == OP_BTFSC) ? !bit_val :
                           (op == OP_BTFSS) ? bit_val : 1'b0;
            end
            S_WRITE_F: begin
                state_d = |mask ? S_WRITE_S : S_IDLE;
                w_d     = wr_w ? result_q : w_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            inst_q   <= '0;
            result_q <= '0;
            w_q      <= '0;
            flags_q  <= '0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            result_q <= result_d;
            w_q      <= w_d;
            flags_q  <= flags_d;
            skip_q   <= skip_d;
        end
    end

    // STATUS is merged from the live statusIn so an earlier write to it is preserved.
    assign done             = (state_q == S_WRITE_F && mask == 3'b000) || state_q == S_WRITE_S;
    assign bus.instReady    = state_q == S_IDLE;
    assign bus.writeCommand = (state_q == S_WRITE_F && wr_f) ? WC_FILE :
                              (state_q == S_WRITE_S) ? WC_STATUS : WC_NONE;
    assign bus.fileAddr     = (state_q == S_IDLE) ? 5'd0 : inst_q[4:0];
    assign bus.writeDataOut = (state_q == S_WRITE_F && wr_f) ? result_q : 8'h00;
    assign bus.statusOut    = (state_q == S_WRITE_S) ?
                              ((bus.statusIn & ~{5'b0, mask}) | ({5'b0, flags_q} & {5'b0, mask})) : 8'h00;
    assign bus.wOut         = w_q;
    assign bus.done         = done;
    assign bus.skipOut      = done && skip_q;
    assign bus.illegalOut   = done && op == OP_ILLEGAL;
endmodule

// File: tb/tb_file_op_sequencer.sv
// tb_file_op_sequencer: directed self-checking bench for file_op_sequencer.
module tb_file_op_sequencer;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    file_op_sequencer_if bus();

    file_op_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [11:0] inst);
        @(negedge clk);
        bus.instValid = 1'b1;
        bus.instIn    = inst;
        @(negedge clk);
        bus.instValid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (bus.instReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.instReady); end
        checks++; if (bus.wOut !== 8'h00) begin errors++; $display("FAIL rst_w got %h want 00", bus.wOut); end
        checks++; if (bus.writeCommand !== 3'b000) begin errors++; $display("FAIL rst_wc got %b want 000", bus.writeCommand); end
        checks++; if ({bus.done, bus.skipOut, bus.illegalOut} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {bus.done, bus.skipOut, bus.illegalOut}); end
        checks++; if ({bus.statusOut, bus.writeDataOut, bus.fileAddr} !== 21'd0) begin errors++; $display("FAIL rst_outs got %h want 0", {bus.statusOut, bus.writeDataOut, bus.fileAddr}); end
        rst = 1'b1;
    endtask

    task automatic test_addwf;
        bus.regfileIn = 8'h0F; bus.statusIn = 8'h00;
        issue(12'h200);
        @(negedge clk); @(negedge clk);
        checks++; if (bus.wOut !== 8'h0F) begin errors++; $display("FAIL movf_w got %h want 0F", bus.wOut); end
        bus.regfileIn = 8'hF1; bus.statusIn = 8'hF8;
        issue(12'h1E8);
        checks++; if ({bus.instReady, bus.writeCommand, bus.fileAddr, bus.done} !== {1'b0, 3'b000, 5'h08, 1'b0}) begin errors++; $display("FAIL addwf_read got %b want 0000010000", {bus.instReady, bus.writeCommand, bus.fileAddr, bus.done}); end
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.writeDataOut, bus.fileAddr, bus.done} !== {3'b010, 8'h00, 5'h08, 1'b0}) begin errors++; $display("FAIL addwf_wrf got %h want %h", {bus.writeCommand, bus.writeDataOut, bus.fileAddr, bus.done}, {3'b010, 8'h00, 5'h08, 1'b0}); end
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.statusOut, bus.done} !== {3'b001, 8'hFF, 1'b1}) begin errors++; $display("FAIL addwf_status got %h want %h", {bus.writeCommand, bus.statusOut, bus.done}, {3'b001, 8'hFF, 1'b1}); end
        @(negedge clk);
        checks++; if ({bus.instReady, bus.done} !== 2'b10) begin errors++; $display("FAIL addwf_idle got %b want 10", {bus.instReady, bus.done}); end
    endtask

    task automatic test_decfsz;
        bus.regfileIn = 8'h01; bus.statusIn = 8'h00;
        issue(12'h2CA);
        @(negedge clk);
        checks++; if ({bus.done, bus.skipOut, bus.writeCommand} !== {1'b1, 1'b1, 3'b000}) begin errors++; $display("FAIL decfsz_done got %b want 11000", {bus.done, bus.skipOut, bus.writeCommand}); end
        @(negedge clk);
        checks++; if ({bus.wOut, bus.instReady, bus.writeCommand, bus.done} !== {8'h00, 1'b1, 3'b000, 1'b0}) begin errors++; $display("FAIL decfsz_after got %h want %h", {bus.wOut, bus.instReady, bus.writeCommand, bus.done}, {8'h00, 1'b1, 3'b000, 1'b0}); end
    endtask

    task automatic test_rrf;
        bus.regfileIn = 8'h01; bus.statusIn = 8'h00;
        issue(12'h329);
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.writeDataOut, bus.done} !== {3'b010, 8'h00, 1'b0}) begin errors++; $display("FAIL rrf_wrf got %h want %h", {bus.writeCommand, bus.writeDataOut, bus.done}, {3'b010, 8'h00, 1'b0}); end
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.statusOut, bus.done} !== {3'b001, 8'h01, 1'b1}) begin errors++; $display("FAIL rrf_status got %h want %h", {bus.writeCommand, bus.statusOut, bus.done}, {3'b001, 8'h01, 1'b1}); end
    endtask

    task automatic test_incf_wrap;
        bus.regfileIn = 8'hFF; bus.statusIn = 8'h00;
        issue(12'h2A5);
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.writeDataOut} !== {3'b010, 8'h00}) begin errors++; $display("FAIL incf_wrf got %h want %h", {bus.writeCommand, bus.writeDataOut}, {3'b010, 8'h00}); end
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.statusOut, bus.done} !== {3'b001, 8'h04, 1'b1}) begin errors++; $display("FAIL incf_status got %h want %h", {bus.writeCommand, bus.statusOut, bus.done}, {3'b001, 8'h04, 1'b1}); end
    endtask

    task automatic test_decf_zero;
        bus.regfileIn = 8'h00; bus.statusIn = 8'h04;
        issue(12'h0C6);
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.done} !== {3'b000, 1'b0}) begin errors++; $display("FAIL decf_wrf got %b want 0000", {bus.writeCommand, bus.done}); end
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.statusOut, bus.done, bus.wOut} !== {3'b001, 8'h00, 1'b1, 8'hFF}) begin errors++; $display("FAIL decf_status got %h want %h", {bus.writeCommand, bus.statusOut, bus.done, bus.wOut}, {3'b001, 8'h00, 1'b1, 8'hFF}); end
    endtask

    task automatic test_subwf;
        bus.regfileIn = 8'h10; bus.statusIn = 8'h07;
        issue(12'h087);
        @(negedge clk); @(negedge clk);
        checks++; if ({bus.writeCommand, bus.statusOut, bus.done, bus.wOut} !== {3'b001, 8'h00, 1'b1, 8'h11}) begin errors++; $display("FAIL subwf_status got %h want %h", {bus.writeCommand, bus.statusOut, bus.done, bus.wOut}, {3'b001, 8'h00, 1'b1, 8'h11}); end
    endtask

    task automatic test_bitops;
        bus.regfileIn = 8'h00; bus.statusIn = 8'h00;
        issue(12'h56C);
        @(negedge clk);
`ifdef SEQ_BITOPS_EN
        checks++; if ({bus.writeCommand, bus.writeDataOut, bus.done, bus.illegalOut} !== {3'b010, 8'h08, 1'b1, 1'b0}) begin errors++; $display("FAIL bsf got %h want %h", {bus.writeCommand, bus.writeDataOut, bus.done, bus.illegalOut}, {3'b010, 8'h08, 1'b1, 1'b0}); end
`else
        checks++; if ({bus.writeCommand, bus.done, bus.illegalOut} !== {3'b000, 1'b1, 1'b1}) begin errors++; $display("FAIL bsf_illegal got %b want 00011", {bus.writeCommand, bus.done, bus.illegalOut}); end
`endif
        bus.regfileIn = 8'h80;
        issue(12'h7E3);
        @(negedge clk);
`ifdef SEQ_BITOPS_EN
        checks++; if ({bus.writeCommand, bus.done, bus.skipOut, bus.illegalOut} !== {3'b000, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL btfss got %b want 000110", {bus.writeCommand, bus.done, bus.skipOut, bus.illegalOut}); end
`else
        checks++; if ({bus.writeCommand, bus.done, bus.skipOut, bus.illegalOut} !== {3'b000, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL btfss_illegal got %b want 000101", {bus.writeCommand, bus.done, bus.skipOut, bus.illegalOut}); end
`endif
    endtask

    task automatic test_illegal_nop;
        issue(12'hA23);
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.done, bus.illegalOut} !== {3'b000, 1'b1, 1'b1}) begin errors++; $display("FAIL goto got %b want 00011", {bus.writeCommand, bus.done, bus.illegalOut}); end
        issue(12'h000);
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.done, bus.illegalOut, bus.wOut} !== {3'b000, 1'b1, 1'b0, 8'h11}) begin errors++; $display("FAIL nop got %h want %h", {bus.writeCommand, bus.done, bus.illegalOut, bus.wOut}, {3'b000, 1'b1, 1'b0, 8'h11}); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.instValid = 1'b1; bus.instIn = 12'h000;
        @(negedge clk);
        checks++; if (bus.instReady !== 1'b0) begin errors++; $display("FAIL b2b_c1 got %b want 0", bus.instReady); end
        @(negedge clk);
        checks++; if ({bus.done, bus.instReady} !== 2'b10) begin errors++; $display("FAIL b2b_c2 got %b want 10", {bus.done, bus.instReady}); end
        @(negedge clk);
        checks++; if ({bus.done, bus.instReady} !== 2'b01) begin errors++; $display("FAIL b2b_c3 got %b want 01", {bus.done, bus.instReady}); end
        @(negedge clk);
        checks++; if (bus.instReady !== 1'b0) begin errors++; $display("FAIL b2b_c4 got %b want 0", bus.instReady); end
        @(negedge clk);
        bus.instValid = 1'b0;
        checks++; if ({bus.done, bus.instReady} !== 2'b10) begin errors++; $display("FAIL b2b_c5 got %b want 10", {bus.done, bus.instReady}); end
    endtask

    task automatic test_reset_mid;
        issue(12'h030);
        @(negedge clk);
        checks++; if ({bus.writeCommand, bus.writeDataOut} !== {3'b010, 8'h11}) begin errors++; $display("FAIL movwf_wrf got %h want %h", {bus.writeCommand, bus.writeDataOut}, {3'b010, 8'h11}); end
        rst = 1'b0;
        #1;
        checks++; if ({bus.writeCommand, bus.instReady, bus.wOut} !== {3'b000, 1'b1, 8'h00}) begin errors++; $display("FAIL mid_rst got %h want %h", {bus.writeCommand, bus.instReady, bus.wOut}, {3'b000, 1'b1, 8'h00}); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.writeCommand, bus.instReady, bus.wOut, bus.done} !== {3'b000, 1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL post_rst%0d got %h want %h", i, {bus.writeCommand, bus.instReady, bus.wOut, bus.done}, {3'b000, 1'b1, 8'h00, 1'b0}); end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.instValid = 1'b0;
        bus.instIn = 12'h000;
        bus.regfileIn = 8'h00;
        bus.statusIn = 8'h00;
        test_reset;
        test_addwf;
        test_decfsz;
        test_rrf;
        test_incf_wrap;
        test_decf_zero;
        test_subwf;
        test_bitops;
        test_illegal_nop;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
